// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder oversampled in the clk domain.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first transfers
// in both directions; the default build is MSB first.
module spi_slave #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic sck_rise_q, sck_rise_d;
  logic sck_fall_q, sck_fall_d;
  logic ss_fall_q, ss_fall_d;
  logic ss_rise_q, ss_rise_d;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  new_data_q, new_data_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;

  logic                  reload;
  logic [DATA_WIDTH-1:0] reload_word;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic                  reload_first_bit;
  logic                  cur_first_bit;
  logic                  shifted_first_bit;

  // Word source on a transfer: buffer if full, else a same-cycle load, else zeros
  assign reload_word = tx_ready_q ? (load ? data_in : '0) : tx_buf_q;

  // Bit-order dependent shift paths
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next           = {mosi_sync_q[1], rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shifted        = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
  assign reload_first_bit  = reload_word[0];
  assign cur_first_bit     = tx_shift_q[0];
  assign shifted_first_bit = tx_shifted[0];
`else
  assign rx_next           = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
  assign tx_shifted        = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
  assign reload_first_bit  = reload_word[DATA_WIDTH-1];
  assign cur_first_bit     = tx_shift_q[DATA_WIDTH-1];
  assign shifted_first_bit = tx_shifted[DATA_WIDTH-1];
`endif

  // Synchroniser shift and registered edge pulses
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    ss_sync_d   = {ss_sync_q[1:0], ss_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sck_rise_d  = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall_d  = ~sck_sync_q[1] & sck_sync_q[2];
    ss_fall_d   = ~ss_sync_q[1] & ss_sync_q[2];
    ss_rise_d   = ss_sync_q[1] & ~ss_sync_q[2];
  end

  // Frame FSM, shift registers and transmit buffer
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out_q;
    new_data_d = 1'b0;
    miso_d     = miso_q;
    reload     = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_q) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          reload    = 1'b1;
          miso_d    = reload_first_bit;
        end
      end
      ACTIVE: begin
        if (ss_rise_q) begin
          // partial word is dropped
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (sck_rise_q) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            data_out_d = rx_next;
            new_data_d = 1'b1;
            bit_cnt_d  = '0;
            reload     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sck_fall_q) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shifted;
            miso_d     = shifted_first_bit;
          end else begin
            // word was just reloaded: present its first bit unshifted
            miso_d = cur_first_bit;
          end
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // A transfer empties the buffer; otherwise a load fills an empty buffer
    if (reload) begin
      tx_shift_d = reload_word;
      tx_ready_d = 1'b1;
    end else if (load && tx_ready_q) begin
      tx_buf_d   = data_in;
      tx_ready_d = 1'b0;
    end

    busy_d = (state_d == ACTIVE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      rx_shift_q  <= '0;
      data_out_q  <= '0;
      new_data_q  <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_rise_q  <= sck_rise_d;
      sck_fall_q  <= sck_fall_d;
      ss_fall_q   <= ss_fall_d;
      ss_rise_q   <= ss_rise_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_shift_q  <= rx_shift_d;
      data_out_q  <= data_out_d;
      new_data_q  <= new_data_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed table-driven bench acting as a mode-0 SPI master at clk/8.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [7:0] data_in;
  logic       load;
  logic       tx_ready;
  logic [7:0] data_out;
  logic       new_data;
  logic       busy;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
  localparam logic [7:0] RST_MOSI = 8'h01;
`else
  localparam bit LSB_FIRST = 1'b0;
  localparam logic [7:0] RST_MOSI = 8'hB6;
`endif

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .data_in  (data_in),
    .load     (load),
    .tx_ready (tx_ready),
    .data_out (data_out),
    .new_data (new_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Strobe monitor: counts new_data pulses, keeps their words, flags wide pulses
  int         strobe_cnt = 0;
  int         wide_cnt   = 0;
  logic [7:0] strobe_words[$];
  logic       nd_prev = 1'b0;
  always @(negedge clk) begin
    if (new_data === 1'b1) begin
      strobe_cnt++;
      strobe_words.push_back(data_out);
      if (nd_prev) wide_cnt++;
    end
    nd_prev = (new_data === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    wait_clk(2);
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  // Shift nbits of a word; SCK low and high phases are 4 clk each
  task automatic word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int pos;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      pos  = LSB_FIRST ? i : 7 - i;
      mosi = mo[pos];
      wait_clk(4);
      mi[pos] = miso;
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
  endtask

  typedef struct {
    logic       do_load;
    logic [7:0] load_val;
    logic [7:0] mosi_val;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] mi, mi2;
  int         cnt0;

  initial begin
    vecs[0] = '{do_load: 1'b1, load_val: 8'hA5, mosi_val: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{do_load: 1'b0, load_val: 8'h00, mosi_val: 8'hC3, exp_miso: 8'h00};
    vecs[2] = '{do_load: 1'b1, load_val: 8'hFF, mosi_val: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{do_load: 1'b1, load_val: 8'h5A, mosi_val: 8'hE7, exp_miso: 8'h5A};

    // Reset with random pins
    rst = 1'b1; load = 1'b0; data_in = 8'h00;
    sck = 1'($urandom_range(1)); ss_n = 1'($urandom_range(1)); mosi = 1'($urandom_range(1));
    wait_clk(2);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_new_data", 32'(new_data), 0);
    chk("rst_busy", 32'(busy), 0);
    sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(8);
    chk("idle_miso", 32'(miso), 0);
    chk("idle_busy", 32'(busy), 0);

    // Table-driven single frames
    foreach (vecs[i]) begin
      if (vecs[i].do_load) begin
        do_load(vecs[i].load_val);
        chk($sformatf("v%0d_tx_ready_full", i), 32'(tx_ready), 0);
      end
      cnt0 = strobe_cnt;
      ss_begin();
      chk($sformatf("v%0d_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_tx_ready_at_ss", i), 32'(tx_ready), 1);
      word(vecs[i].mosi_val, 8, mi);
      ss_end();
      chk($sformatf("v%0d_strobes", i), 32'(strobe_cnt - cnt0), 1);
      chk($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].mosi_val));
      chk($sformatf("v%0d_master_rx", i), 32'(mi), 32'(vecs[i].exp_miso));
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
      chk($sformatf("v%0d_miso_idle", i), 32'(miso), 0);
    end

    // Back-to-back words under one ss_n low
    do_load(8'h81);
    cnt0 = strobe_cnt;
    strobe_words.delete();
    ss_begin();
    do_load(8'h7E);
    chk("b2b_tx_ready_full", 32'(tx_ready), 0);
    word(8'h11, 8, mi);
    word(8'h22, 8, mi2);
    ss_end();
    chk("b2b_strobes", 32'(strobe_cnt - cnt0), 2);
    if (strobe_words.size() == 2) begin
      chk("b2b_word0", 32'(strobe_words[0]), 32'h11);
      chk("b2b_word1", 32'(strobe_words[1]), 32'h22);
    end else begin
      chk("b2b_word_count", 32'(strobe_words.size()), 2);
    end
    chk("b2b_master_rx0", 32'(mi), 32'h81);
    chk("b2b_master_rx1", 32'(mi2), 32'h7E);

    // Second load while buffer full is ignored
    do_load(8'h55);
    do_load(8'h66);
    chk("ign_tx_ready", 32'(tx_ready), 0);
    ss_begin();
    word(8'h99, 8, mi);
    ss_end();
    chk("ign_master_rx", 32'(mi), 32'h55);
    chk("ign_data_out", 32'(data_out), 32'h99);

    // Abort after 5 bits
    do_load(8'h33);
    cnt0 = strobe_cnt;
    ss_begin();
    word(8'hF0, 5, mi);
    ss_end();
    chk("abort_strobes", 32'(strobe_cnt - cnt0), 0);
    chk("abort_data_out", 32'(data_out), 32'h99);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_miso", 32'(miso), 0);
    do_load(8'h6B);
    ss_begin();
    word(8'h4D, 8, mi);
    ss_end();
    chk("post_abort_data_out", 32'(data_out), 32'h4D);
    chk("post_abort_master_rx", 32'(mi), 32'h6B);

    // Reset after bit 3 of a frame
    do_load(8'h12);
    ss_begin();
    word(8'h77, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_data_out", 32'(data_out), 0);
    chk("mrst_tx_ready", 32'(tx_ready), 1);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_miso", 32'(miso), 0);
    chk("mrst_new_data", 32'(new_data), 0);
    rst = 1'b0;
    cnt0 = strobe_cnt;
    word(8'h77, 5, mi);
    wait_clk(6);
    chk("mrst_rest_ignored", 32'(strobe_cnt - cnt0), 0);
    chk("mrst_rest_busy", 32'(busy), 0);
    ss_end();
    do_load(8'h2E);
    cnt0 = strobe_cnt;
    ss_begin();
    word(RST_MOSI, 8, mi);
    ss_end();
    chk("mrst_next_strobes", 32'(strobe_cnt - cnt0), 1);
    chk("mrst_next_data_out", 32'(data_out), 32'(RST_MOSI));
    chk("mrst_next_master_rx", 32'(mi), 32'h2E);

    chk("strobe_width", 32'(wide_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
